// File: rtl/conditioner_pkg.sv
// Shared constants and types for the four-bit switch conditioner.
package conditioner_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned NUM_BITS    = 4;

  // Decoder input mapping on sw_in / sw_out
  localparam int unsigned IDX_A = 3;
  localparam int unsigned IDX_B = 2;
  localparam int unsigned IDX_C = 1;
  localparam int unsigned IDX_D = 0;

  typedef enum logic {
    STABLE   = 1'b0,
    CHANGING = 1'b1
  } deb_state_e;

endpackage

// File: rtl/switch_conditioner_4bit_if.sv
// Raw switch levels in, conditioned levels and status flags out.
interface switch_conditioner_4bit_if;
  import conditioner_pkg::*;

  logic [NUM_BITS-1:0] sw_in;
  logic [NUM_BITS-1:0] sw_out;
  logic                changed;
  logic                valid;

  modport master (output sw_in, input sw_out, input changed, input valid);
  modport slave  (input sw_in, output sw_out, output changed, output valid);

endinterface

// File: rtl/debounce_bit.sv
// One switch bit: two-flop synchroniser followed by a counting debounce FSM.
module debounce_bit
  import conditioner_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic toggle_c
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   sync_q;
  logic [CNT_W-1:0]       cnt;
  deb_state_e             state;

  assign sync_q = sync_r[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_r <= '0;
    else        sync_r <= {sync_r[SYNC_STAGES-2:0], raw};
  end

  // Qualifying edge: the difference has now persisted STABLE_CYCLES cycles
  assign toggle_c = (state == CHANGING) && (sync_q != level) && (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= '0;
      level <= 1'b0;
    end else begin
      case (state)
        STABLE: begin
          if (sync_q != level) begin
            state <= CHANGING;
            cnt   <= CNT_W'(1);
          end
        end
        CHANGING: begin
          if (sync_q == level) begin
            state <= STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= STABLE;
            cnt   <= '0;
            level <= ~level;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/switch_conditioner_4bit.sv
// Debounces four raw switch levels for the 4-to-2 decoder; adds change strobe and startup valid.
module switch_conditioner_4bit
  import conditioner_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter int unsigned CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  switch_conditioner_4bit_if.slave  bus
);

  localparam logic [CNT_W-1:0] START_DONE = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [NUM_BITS-1:0] out_bits;
  logic [NUM_BITS-1:0] toggles_c;
  logic [CNT_W-1:0]    start_cnt;
  logic                valid_r;
  logic                changed_r;

  for (genvar i = 0; i < NUM_BITS; i++) begin : g_bit
    debounce_bit #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .CNT_W         (CNT_W)
    ) u_bit (
      .clk      (clk),
      .rst_n    (rst_n),
      .raw      (bus.sw_in[i]),
      .level    (out_bits[i]),
      .toggle_c (toggles_c[i])
    );
  end

  // Startup qualification counter saturates; valid latches until reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_cnt <= '0;
      valid_r   <= 1'b0;
      changed_r <= 1'b0;
    end else begin
      if (start_cnt != START_DONE) start_cnt <= start_cnt + CNT_W'(1);
      if (start_cnt == START_LAST) valid_r <= 1'b1;
      changed_r <= valid_r & (|toggles_c);
    end
  end

  assign bus.sw_out  = {out_bits[IDX_A], out_bits[IDX_B], out_bits[IDX_C], out_bits[IDX_D]};
  assign bus.changed = changed_r;
  assign bus.valid   = valid_r;

endmodule

// File: tb/tb_switch_conditioner_4bit.sv
// Bench for switch_conditioner_4bit with STABLE_CYCLES=4 and a run-length reference model.
module tb_switch_conditioner_4bit;

  localparam int S = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  switch_conditioner_4bit_if bus ();

  switch_conditioner_4bit #(.STABLE_CYCLES(S), .CNT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Reference: sync_q is sw_in two edges late; a bit flips after S consecutive differing cycles
  logic [3:0] m_out, m_d1, m_d2, m_tog;
  int         m_run [4];
  int         m_edges;
  logic       m_valid, m_changed;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out = '0; m_d1 = '0; m_d2 = '0; m_edges = 0; m_valid = 1'b0; m_changed = 1'b0;
      for (int b = 0; b < 4; b++) m_run[b] = 0;
    end else begin
      m_tog = '0;
      for (int b = 0; b < 4; b++) begin
        if (m_d2[b] != m_out[b]) begin
          m_run[b]++;
          if (m_run[b] == S) begin m_tog[b] = 1'b1; m_run[b] = 0; end
        end else m_run[b] = 0;
      end
      m_changed = (m_tog != 4'b0) && m_valid;
      m_out     = m_out ^ m_tog;
      m_d2      = m_d1;
      m_d1      = bus.sw_in;
      if (m_edges < S) m_edges++;
      m_valid   = (m_edges >= S);
    end
  end

  task automatic do_reset;
    rst_n = 1'b0; bus.sw_in = 4'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (S + 1) @(negedge clk);
  endtask

  task automatic test_reset;
    logic exp_v;
    bus.sw_in = 4'b0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.sw_out !== 4'b0) begin errors++; $display("FAIL reset_sw_out got %b want 0000", bus.sw_out); end
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.valid); end
    checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL reset_changed got %b want 0", bus.changed); end
    rst_n = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      exp_v = (k >= S);
      checks++; if (bus.valid !== exp_v) begin errors++; $display("FAIL startup_valid edge %0d got %b want %b", k, bus.valid, exp_v); end
      checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL startup_changed edge %0d got %b want 0", k, bus.changed); end
      checks++; if (bus.sw_out !== 4'b0) begin errors++; $display("FAIL startup_sw_out edge %0d got %b want 0000", k, bus.sw_out); end
    end
  endtask

  task automatic test_single_bit;
    logic [3:0] exp_o;
    do_reset();
    bus.sw_in = 4'b0001;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_o = (k >= 6) ? 4'b0001 : 4'b0000;
      checks++; if (bus.sw_out !== exp_o) begin errors++; $display("FAIL single_sw_out edge %0d got %b want %b", k, bus.sw_out, exp_o); end
      checks++; if (bus.changed !== (k == 6)) begin errors++; $display("FAIL single_changed edge %0d got %b want %b", k, bus.changed, (k == 6)); end
    end
  endtask

  task automatic test_glitch(input int len, input bit pass);
    int pulses = 0;
    bit saw    = 1'b0;
    do_reset();
    bus.sw_in = 4'b0100;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == len) bus.sw_in = 4'b0000;
      if (bus.changed === 1'b1) pulses++;
      if (bus.sw_out === 4'b0100) saw = 1'b1;
      checks++; if (bus.sw_out !== m_out) begin errors++; $display("FAIL glitch%0d_model edge %0d got %b want %b", len, k, bus.sw_out, m_out); end
    end
    checks++; if (saw !== pass) begin errors++; $display("FAIL glitch%0d_reached got %b want %b", len, saw, pass); end
    checks++; if (pulses != (pass ? 2 : 0)) begin errors++; $display("FAIL glitch%0d_pulses got %0d want %0d", len, pulses, pass ? 2 : 0); end
  endtask

  task automatic test_simultaneous;
    int pulses = 0;
    logic [3:0] exp_o;
    do_reset();
    bus.sw_in = 4'b1010;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (bus.changed === 1'b1) pulses++;
      exp_o = (k >= 6) ? 4'b1010 : 4'b0000;
      checks++; if (bus.sw_out !== exp_o) begin errors++; $display("FAIL simul_sw_out edge %0d got %b want %b", k, bus.sw_out, exp_o); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL simul_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_staggered;
    int pulses = 0;
    logic [3:0] exp_o;
    do_reset();
    bus.sw_in = 4'b1000;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) bus.sw_in = 4'b1010;
      if (bus.changed === 1'b1) pulses++;
      exp_o = (k < 6) ? 4'b0000 : (k == 6) ? 4'b1000 : 4'b1010;
      checks++; if (bus.sw_out !== exp_o) begin errors++; $display("FAIL stagger_sw_out edge %0d got %b want %b", k, bus.sw_out, exp_o); end
      checks++; if (bus.changed !== (k == 6 || k == 7)) begin errors++; $display("FAIL stagger_changed edge %0d got %b", k, bus.changed); end
    end
    checks++; if (pulses != 2) begin errors++; $display("FAIL stagger_pulses got %0d want 2", pulses); end
  endtask

  task automatic test_reset_mid;
    int pulses = 0;
    logic [3:0] exp_o;
    do_reset();
    bus.sw_in = 4'b1111;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus.valid !== 1'b0) begin errors++; $display("FAIL midreset_valid got %b want 0", bus.valid); end
    checks++; if (bus.sw_out !== 4'b0) begin errors++; $display("FAIL midreset_sw_out got %b want 0000", bus.sw_out); end
    checks++; if (bus.changed !== 1'b0) begin errors++; $display("FAIL midreset_changed got %b want 0", bus.changed); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (bus.changed === 1'b1) pulses++;
      exp_o = (k >= 6) ? 4'b1111 : 4'b0000;
      checks++; if (bus.sw_out !== exp_o) begin errors++; $display("FAIL midreset_out edge %0d got %b want %b", k, bus.sw_out, exp_o); end
      checks++; if (bus.valid !== (k >= S)) begin errors++; $display("FAIL midreset_vld edge %0d got %b", k, bus.valid); end
    end
    checks++; if (pulses != 1) begin errors++; $display("FAIL midreset_pulses got %0d want 1", pulses); end
  endtask

  task automatic test_sweep;
    int pulses = 0;
    do_reset();
    for (int code = 0; code < 16; code++) begin
      bus.sw_in = 4'(code);
      repeat (10) begin
        @(negedge clk);
        if (bus.changed === 1'b1) pulses++;
        checks++; if (bus.sw_out !== m_out) begin errors++; $display("FAIL sweep_model code %0d got %b want %b", code, bus.sw_out, m_out); end
      end
      checks++; if (bus.sw_out !== 4'(code)) begin errors++; $display("FAIL sweep_settled got %b want %b", bus.sw_out, 4'(code)); end
    end
    checks++; if (pulses != 15) begin errors++; $display("FAIL sweep_pulses got %0d want 15", pulses); end
  endtask

  task automatic test_random;
    int hold;
    do_reset();
    for (int n = 0; n < 60; n++) begin
      bus.sw_in = 4'($urandom);
      hold = int'($urandom_range(1, 8));
      repeat (hold) begin
        @(negedge clk);
        checks++; if (bus.sw_out !== m_out) begin errors++; $display("FAIL rand_sw_out got %b want %b", bus.sw_out, m_out); end
        checks++; if (bus.changed !== m_changed) begin errors++; $display("FAIL rand_changed got %b want %b", bus.changed, m_changed); end
        checks++; if (bus.valid !== m_valid) begin errors++; $display("FAIL rand_valid got %b want %b", bus.valid, m_valid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_glitch(3, 1'b0);
    test_glitch(4, 1'b1);
    test_simultaneous();
    test_staggered();
    test_reset_mid();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
